// File: rtl/rom_responder_if.sv
// Bus and load-port bundle for rom_responder: CPU multiplexed nibble bus,
// program-store load handshake and sticky status flags.
interface rom_responder_if;
    logic       sync;
    logic       rom_cmd;
    logic [3:0] cpu_data_i;
    logic       cpu_data_en;
    logic [3:0] rom_data_o;
    logic       rom_data_oe;
    logic       load_valid;
    logic [3:0] load_nibble;
    logic       load_ready;
    logic       sync_err;
    logic       bus_conflict;

    modport slave (
        input  sync, rom_cmd, cpu_data_i, cpu_data_en, load_valid, load_nibble,
        output rom_data_o, rom_data_oe, load_ready, sync_err, bus_conflict
    );

    modport master (
        output sync, rom_cmd, cpu_data_i, cpu_data_en, load_valid, load_nibble,
        input  rom_data_o, rom_data_oe, load_ready, sync_err, bus_conflict
    );
endinterface

// File: rtl/rom_responder.sv
// Program-memory responder on a 4-bit multiplexed CPU bus: tracks the 8-phase
// instruction cycle, returns opcode nibbles in M1/M2, loads store while idle.
module rom_responder #(
    parameter int unsigned ADDR_BITS = 8,       // 4..8
    parameter logic [3:0]  CHIP_ID   = 4'h0
) (
    input logic        clock,
    input logic        reset,
    rom_responder_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [3:0] {
        IDLE, A1, A2, A3, M1, M2, X1, X2, X3
    } phase_t;

    phase_t               phase;
    logic [3:0]           addr_lo;
    logic [3:0]           addr_hi;
    logic [7:0]           addr_full;
    logic [ADDR_BITS-1:0] fetch_idx;
    logic [ADDR_BITS-1:0] idx;
    logic [7:0]           mem [DEPTH];
    logic [7:0]           fetch_byte;
    logic [7:0]           held_byte;
    logic [3:0]           data_q;
    logic                 oe_q;
    logic                 sync_err_q;
    logic                 conflict_q;

    logic [ADDR_BITS-1:0] load_addr;
    logic [3:0]           load_hi;
    logic                 expect_high;
    logic                 accept;

    assign addr_full  = {addr_hi, addr_lo};
    assign fetch_idx  = addr_full[ADDR_BITS-1:0];
    assign fetch_byte = mem[fetch_idx];
    assign held_byte  = mem[idx];

    assign bus.rom_data_o   = data_q;
    assign bus.rom_data_oe  = oe_q;
    assign bus.sync_err     = sync_err_q;
    assign bus.bus_conflict = conflict_q;
    assign bus.load_ready   = (phase == IDLE);

    assign accept = bus.load_valid && (phase == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase      <= IDLE;
            data_q     <= '0;
            oe_q       <= 1'b0;
            sync_err_q <= 1'b0;
            conflict_q <= 1'b0;
            addr_lo    <= '0;
            addr_hi    <= '0;
            idx        <= '0;
        end else begin
            if (bus.cpu_data_en && oe_q)
                conflict_q <= 1'b1;

            // A stray sync mid-cycle resynchronises to A1 and cancels any drive.
            if (bus.sync && phase != IDLE && phase != X3) begin
                phase      <= A1;
                sync_err_q <= 1'b1;
                oe_q       <= 1'b0;
                data_q     <= '0;
            end else begin
                case (phase)
                    IDLE: if (bus.sync) phase <= A1;
                    A1: begin
                        addr_lo <= bus.cpu_data_i;
                        phase   <= A2;
                    end
                    A2: begin
                        addr_hi <= bus.cpu_data_i;
                        phase   <= A3;
                    end
                    A3: begin
                        idx <= fetch_idx;
                        if (bus.rom_cmd && bus.cpu_data_i == CHIP_ID) begin
                            data_q <= fetch_byte[7:4];
                            oe_q   <= 1'b1;
                        end
                        phase <= M1;
                    end
                    M1: begin
                        if (oe_q) data_q <= held_byte[3:0];
                        phase <= M2;
                    end
                    M2: begin
                        oe_q   <= 1'b0;
                        data_q <= '0;
                        phase  <= X1;
                    end
                    X1: phase <= X2;
                    X2: phase <= X3;
                    X3: begin
                        if (bus.sync) begin
                            phase <= A1;
                        end else begin
                            phase      <= IDLE;
                            sync_err_q <= 1'b1;
                        end
                    end
                    default: phase <= IDLE;
                endcase
            end
        end
    end

    // Nibble pairing survives a non-idle gap; only reset discards a half byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_addr   <= '0;
            load_hi     <= '0;
            expect_high <= 1'b1;
        end else if (accept) begin
            if (expect_high) begin
                load_hi     <= bus.load_nibble;
                expect_high <= 1'b0;
            end else begin
                load_addr   <= load_addr + 1'b1;
                expect_high <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !expect_high)
            mem[load_addr] <= {load_hi, bus.load_nibble};
    end
endmodule

// File: tb/tb_rom_responder.sv
// Directed scoreboard bench for rom_responder: load, fetch, chip select,
// sync loss, bus conflict, address wrap and asynchronous reset mid-fetch.
module tb_rom_responder;
    localparam logic [3:0] CHIP = 4'h0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rom_responder_if bus();

    rom_responder #(.ADDR_BITS(8), .CHIP_ID(CHIP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [4:0] sbq[$];
    logic [7:0] model [256];
    int         la = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic cmd, input logic [3:0] d, input logic en);
        bus.sync        = s;
        bus.rom_cmd     = cmd;
        bus.cpu_data_i  = d;
        bus.cpu_data_en = en;
    endtask

    task automatic pop_chk(input string tag);
        logic [4:0] v;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty-queue expected=entry", tag);
        end else begin
            v = sbq.pop_front();
            chk(tag, {3'b000, bus.rom_data_oe, bus.rom_data_o}, {3'b000, v});
        end
    endtask

    task automatic load(input logic [7:0] b);
        bus.load_valid  = 1'b1;
        bus.load_nibble = b[7:4];
        tick();
        bus.load_nibble = b[3:0];
        tick();
        bus.load_valid  = 1'b0;
        model[la] = b;
        la = (la + 1) % 256;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        la = 0;
    endtask

    // Starts in IDLE or X3 by raising sync; returns in X3 unless reset in M1.
    task automatic fetch(input logic [7:0] a, input logic [3:0] chip, input logic cmd,
                         input logic en_m1, input logic rst_m1);
        logic       sel;
        logic [7:0] b;
        sel = cmd && (chip == CHIP);
        b   = model[a];
        drive(1'b1, 1'b0, 4'h0, 1'b0); tick();
        chk("ready_a1", {7'd0, bus.load_ready}, 8'd0);
        drive(1'b0, 1'b0, a[3:0], 1'b0); tick();
        drive(1'b0, 1'b0, a[7:4], 1'b0); tick();
        drive(1'b0, cmd, chip, 1'b0);
        sbq.push_back(sel ? {1'b1, b[7:4]} : 5'h00);
        sbq.push_back(sel ? {1'b1, b[3:0]} : 5'h00);
        sbq.push_back(5'h00);
        tick();
        pop_chk("m1");
        if (rst_m1) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_oe", {7'd0, bus.rom_data_oe}, 8'd0);
            chk("rst_ready", {7'd0, bus.load_ready}, 8'd1);
            sbq.delete();
            tick();
            reset = 1'b0;
            la = 0;
            return;
        end
        drive(1'b0, 1'b0, 4'h0, en_m1); tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        pop_chk("m2");
        tick();
        pop_chk("x1");
        tick();
        tick();
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        bus.load_valid  = 1'b0;
        bus.load_nibble = 4'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_oe", {7'd0, bus.rom_data_oe}, 8'd0);
        chk("rst_data", {4'd0, bus.rom_data_o}, 8'd0);
        chk("rst_ready", {7'd0, bus.load_ready}, 8'd1);
        chk("rst_syncerr", {7'd0, bus.sync_err}, 8'd0);
        chk("rst_conflict", {7'd0, bus.bus_conflict}, 8'd0);

        load(8'hD5);
        load(8'h3C);
        fetch(8'h00, CHIP, 1'b1, 1'b0, 1'b0);
        fetch(8'h00, CHIP, 1'b1, 1'b0, 1'b0);
        fetch(8'h01, CHIP, 1'b1, 1'b0, 1'b0);

        fetch(8'h00, CHIP + 4'h1, 1'b1, 1'b1, 1'b0);
        fetch(8'h01, CHIP, 1'b0, 1'b1, 1'b0);
        chk("unsel_conflict", {7'd0, bus.bus_conflict}, 8'd0);
        chk("chain_syncerr", {7'd0, bus.sync_err}, 8'd0);

        fetch(8'h01, CHIP, 1'b1, 1'b1, 1'b0);
        chk("conflict_set", {7'd0, bus.bus_conflict}, 8'd1);

        drive(1'b0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("drop_syncerr", {7'd0, bus.sync_err}, 8'd1);
        chk("drop_ready", {7'd0, bus.load_ready}, 8'd1);
        repeat (6) tick();
        chk("idle_oe", {7'd0, bus.rom_data_oe}, 8'd0);
        chk("conflict_sticky", {7'd0, bus.bus_conflict}, 8'd1);

        // High nibble offered, then a fetch, then the low nibble.
        bus.load_valid  = 1'b1;
        bus.load_nibble = 4'hA;
        tick();
        bus.load_valid  = 1'b0;
        fetch(8'h01, CHIP, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0); tick();
        bus.load_valid  = 1'b1;
        bus.load_nibble = 4'h7;
        tick();
        bus.load_valid  = 1'b0;
        model[la] = 8'hA7;
        la = la + 1;
        fetch(8'h02, CHIP, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0); tick();

        // Stray sync during A2.
        do_reset();
        drive(1'b1, 1'b0, 4'h0, 1'b0); tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 4'h0, 1'b0); tick();
        chk("stray_syncerr", {7'd0, bus.sync_err}, 8'd1);
        chk("stray_ready", {7'd0, bus.load_ready}, 8'd0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // Half byte then reset, then 257 bytes wrapping onto address 0.
        do_reset();
        bus.load_valid  = 1'b1;
        bus.load_nibble = 4'hF;
        tick();
        bus.load_valid  = 1'b0;
        do_reset();
        for (int i = 0; i < 257; i++) load(8'((i * 37 + 11) & 8'hFF));
        chk("wrap_model", model[0], 8'((256 * 37 + 11) & 8'hFF));
        fetch(8'h00, CHIP, 1'b1, 1'b0, 1'b0);
        fetch(8'h01, CHIP, 1'b1, 1'b0, 1'b0);
        fetch(8'hFF, CHIP, 1'b1, 1'b0, 1'b0);

        fetch(8'h02, CHIP, 1'b1, 1'b0, 1'b1);
        load(8'h99);
        fetch(8'h00, CHIP, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
